// File: rtl/serial_adder.sv
// Bit-serial LSB-first adder: one full-adder cell plus a carry flip-flop.
// Define SERIAL_ADDER_OVF_EN to add the registered signed-overflow output ovf.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADDER_OVF_EN
    output logic             ovf,
`endif
    output logic             cout
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_FIN
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic             accept;
    logic             last;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] s_sh;
    logic [WIDTH-1:0] s_nx;
    logic             carry;
    logic             s_bit;
    logic             c_nx;
    logic [CW-1:0]    cnt;

    // The single full-adder cell working on the current LSBs.
    assign s_bit = a_sh[0] ^ b_sh[0] ^ carry;
    assign c_nx  = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);
    assign s_nx  = {s_bit, {(WIDTH-1){1'b0}}} | (s_sh >> 1);
    assign last  = (cnt == CW'(WIDTH - 1));

    assign busy = (state == S_SHIFT);
    assign done = (state == S_FIN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    accept   = 1'b1;
                    state_nx = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (last) begin
                    state_nx = S_FIN;
                end
            end
            S_FIN: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh  <= '0;
            b_sh  <= '0;
            s_sh  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
        end else if (accept) begin
            a_sh  <= a;
            b_sh  <= b;
            s_sh  <= '0;
            carry <= cin;
            cnt   <= '0;
        end else if (state == S_SHIFT) begin
            a_sh  <= a_sh >> 1;
            b_sh  <= b_sh >> 1;
            s_sh  <= s_nx;
            carry <= c_nx;
            cnt   <= cnt + CW'(1);
        end
    end

    // Result registers change only at the completion edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum  <= '0;
            cout <= 1'b0;
        end else if (state == S_SHIFT && last) begin
            sum  <= s_nx;
            cout <= c_nx;
        end
    end

`ifdef SERIAL_ADDER_OVF_EN
    // carry still holds the carry into the MSB at the completion edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (state == S_SHIFT && last) begin
            ovf <= carry ^ c_nx;
        end
    end
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Directed and modelled-random bench for serial_adder at WIDTH=8.
module tb_serial_adder;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       cout;
`ifdef SERIAL_ADDER_OVF_EN
    logic       ovf;
`endif

    int checks = 0;
    int errors = 0;

    serial_adder #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
`ifdef SERIAL_ADDER_OVF_EN
        .ovf   (ovf),
`endif
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Entered and left at posedge+1 with the DUT idle.
    task automatic run_op(input string tag, input logic [7:0] ta,
                          input logic [7:0] tb, input logic tc,
                          input logic [7:0] es, input logic ec,
                          input logic hold_en, input logic [7:0] hold_v);
        int   lat;
        int   bc;
        logic got;
        a     = ta;
        b     = tb;
        cin   = tc;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = ~ta;
        b     = ~tb;
        cin   = ~tc;
        lat   = 0;
        bc    = busy ? 1 : 0;
        got   = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if (done) begin
                got = 1'b1;
            end else begin
                if (busy) bc++;
                if (hold_en && lat == 4)
                    check({tag, "_hold"}, 32'(sum), 32'(hold_v));
            end
        end
        if (!got) begin
            check({tag, "_timeout"}, 32'(got), 32'd1);
        end else begin
            check({tag, "_lat"}, lat, 8);
            check({tag, "_busy"}, bc, 8);
            check({tag, "_sum"}, 32'(sum), 32'(es));
            check({tag, "_cout"}, 32'(cout), 32'(ec));
            @(posedge clk);
            #1;
            check({tag, "_pulse"}, 32'(done), 32'd0);
        end
    endtask

    initial begin
        logic [7:0] ra;
        logic [7:0] rb;
        logic       rc;
        logic [8:0] ex;
        int         d1;
        int         d2;
        int         nd;
        logic [7:0] s1;
        logic [7:0] s2;
        logic       seen;

        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        cin   = 1'b0;
        #12;
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_sum", 32'(sum), 0);
        check("rst_cout", 32'(cout), 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        run_op("zero", 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        run_op("wrap", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
        run_op("mix", 8'h5A, 8'h3C, 1'b1, 8'h97, 1'b0, 1'b1, 8'h00);
        run_op("allones", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 8'h00);

        for (int n = 0; n < 200; n++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            rc = 1'($urandom_range(0, 1));
            ex = {1'b0, ra} + {1'b0, rb} + {8'h00, rc};
            run_op("rand", ra, rb, rc, ex[7:0], ex[8], 1'b0, 8'h00);
        end

        // start held high: ops accepted only from IDLE.
        a     = 8'h10;
        b     = 8'h20;
        cin   = 1'b0;
        start = 1'b1;
        d1    = -1;
        d2    = -1;
        nd    = 0;
        s1    = '0;
        s2    = '0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            if (i == 3) begin
                a = 8'h01;
                b = 8'h02;
            end
            if (done) begin
                nd++;
                if (d1 < 0) begin
                    d1 = i;
                    s1 = sum;
                end else if (d2 < 0) begin
                    d2 = i;
                    s2 = sum;
                end
            end
        end
        start = 1'b0;
        check("ign_first", d1, 8);
        check("ign_space", d2 - d1, 10);
        check("ign_count", nd, 3);
        check("ign_sum1", 32'(s1), 32'h30);
        check("ign_sum2", 32'(s2), 32'h03);

        // Asynchronous abort four cycles into SHIFT.
        a     = 8'h12;
        b     = 8'h34;
        cin   = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("abort_busy", 32'(busy), 0);
        check("abort_done", 32'(done), 0);
        check("abort_sum", 32'(sum), 0);
        check("abort_cout", 32'(cout), 0);
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (done) seen = 1'b1;
        end
        check("abort_nodone", 32'(seen), 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        run_op("after", 8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0, 8'h00);

`ifdef SERIAL_ADDER_OVF_EN
        run_op("ovf_pos", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b0, 8'h00);
        check("ovf_pos_ovf", 32'(ovf), 1);
        run_op("ovf_neg", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
        check("ovf_neg_ovf", 32'(ovf), 1);
        run_op("ovf_none", 8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0, 8'h00);
        check("ovf_none_ovf", 32'(ovf), 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
